// File: rtl/usb_rx_ctrl_if.sv
// ---------------------------------------------------------------------------
// usb_rx_ctrl_if
// Groups the signals between the USB RX control FSM and its surroundings
// (bit/byte timer, receive shift register, EOP detector, RX FIFO).
//
//   slave  : the controller side (usb_rx_ctrl)
//   master : the datapath / FIFO side (or a testbench standing in for it)
//
// Signals
//   d_edge         datapath -> ctrl  one-cycle pulse on a D+ transition
//   eop            datapath -> ctrl  SE0 level currently on the bus
//   shift_enable   timer    -> ctrl  one-cycle bit strobe
//   byte_received  timer    -> ctrl  one-cycle pulse, 8 bits shifted
//   rcv_data[7:0]  shifter  -> ctrl  parallel byte, also the FIFO write data
//   fifo_full      fifo     -> ctrl  FIFO cannot accept a write
//   rcving         ctrl -> out       packet reception in progress
//   w_enable       ctrl -> fifo      one-cycle write strobe
//   r_error        ctrl -> out       sticky receive error
//   disable_timer  ctrl -> timer     holds the timer idle when high
//   pid_out[3:0]   ctrl -> out       last valid PID
//   pid_valid      ctrl -> out       one-cycle pulse when pid_out updates
//   byte_count[6:0]ctrl -> out       data bytes stored in current packet
// ---------------------------------------------------------------------------
interface usb_rx_ctrl_if;
  logic       d_edge;
  logic       eop;
  logic       shift_enable;
  logic       byte_received;
  logic [7:0] rcv_data;
  logic       fifo_full;
  logic       rcving;
  logic       w_enable;
  logic       r_error;
  logic       disable_timer;
  logic [3:0] pid_out;
  logic       pid_valid;
  logic [6:0] byte_count;

  modport slave (
    input  d_edge, eop, shift_enable, byte_received, rcv_data, fifo_full,
    output rcving, w_enable, r_error, disable_timer, pid_out, pid_valid,
           byte_count
  );

  modport master (
    output d_edge, eop, shift_enable, byte_received, rcv_data, fifo_full,
    input  rcving, w_enable, r_error, disable_timer, pid_out, pid_valid,
           byte_count
  );
endinterface

// File: rtl/usb_rx_ctrl.sv
// ---------------------------------------------------------------------------
// usb_rx_ctrl
// Receive control unit for the USB RX path. Enables the bit/byte timer,
// checks the SYNC and PID bytes, writes data bytes into the RX FIFO and
// validates EOP framing. Any framing or overflow problem parks the FSM in an
// error path that waits for the bus to return to idle.
//
// Ports
//   clk   system clock
//   rst   synchronous reset, active-high
//   bus   usb_rx_ctrl_if.slave (datapath inputs, control/status outputs)
//
// Parameters
//   MAX_BYTES  data bytes allowed after the PID; one more is an error
//   SYNC_BYTE  required first byte as assembled in rcv_data
//
// All outputs come from registers or from a decode of the state register,
// so there is no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module usb_rx_ctrl #(
  parameter int         MAX_BYTES = 64,
  parameter logic [7:0] SYNC_BYTE = 8'h80
) (
  input logic           clk,
  input logic           rst,
  usb_rx_ctrl_if.slave  bus
);

  localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

  typedef enum logic [3:0] {
    IDLE,
    EIDLE,
    SYNC_WAIT,
    SYNC_CHK,
    PID_WAIT,
    PID_CHK,
    DATA_WAIT,
    STORE,
    EOP1,
    EOP2,
    ERR,
    ERR_EOP
  } state_t;

  state_t     state, next;
  logic [2:0] bit_cnt;
  logic       r_error_q;
  logic [3:0] pid_out_q;
  logic       pid_valid_q;
  logic [6:0] byte_count_q;
  // Write permission for the byte in flight, captured on its byte_received.
  // Sampling fifo_full/byte_count one cycle early lets w_enable be a pure
  // state decode in STORE instead of a path from the fifo_full pin.
  logic       wr_ok;

  logic idle_st;
  logic timer_en;
  logic pid_ok;

  assign idle_st  = (state == IDLE) || (state == EIDLE);
  assign timer_en = !(idle_st || (state == EOP2));
  assign pid_ok   = (bus.rcv_data[7:4] == ~bus.rcv_data[3:0]);

  // ---------------- next-state logic ----------------
  always_comb begin
    next = state;
    case (state)
      IDLE, EIDLE: begin
        if (bus.d_edge) next = SYNC_WAIT;
      end
      SYNC_WAIT: begin
        if (bus.eop)                next = ERR;
        else if (bus.byte_received) next = SYNC_CHK;
      end
      SYNC_CHK: begin
        if (bus.eop)                        next = ERR;
        else if (bus.rcv_data == SYNC_BYTE) next = PID_WAIT;
        else                                next = ERR;
      end
      PID_WAIT: begin
        if (bus.eop)                next = ERR;
        else if (bus.byte_received) next = PID_CHK;
      end
      PID_CHK: begin
        if (bus.eop)     next = ERR;
        else if (pid_ok) next = DATA_WAIT;
        else             next = ERR;
      end
      DATA_WAIT: begin
        // A full byte wins over an EOP arriving in the same cycle.
        if (bus.byte_received)
          next = STORE;
        else if (bus.eop && bus.shift_enable)
          next = (bit_cnt == 3'd0) ? EOP1 : ERR;  // EOP must sit on a byte boundary
      end
      STORE: begin
        next = wr_ok ? DATA_WAIT : ERR;
      end
      EOP1: begin
        // SE0 must last a second bit time.
        if (bus.shift_enable) next = bus.eop ? EOP2 : ERR;
      end
      EOP2: begin
        if (bus.d_edge) next = IDLE;
      end
      ERR: begin
        if (bus.eop) next = ERR_EOP;
      end
      ERR_EOP: begin
        if (bus.d_edge) next = EIDLE;
      end
      default: next = IDLE;
    endcase
  end

  // ---------------- state and datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= 3'd0;
      r_error_q    <= 1'b0;
      pid_out_q    <= 4'd0;
      pid_valid_q  <= 1'b0;
      byte_count_q <= 7'd0;
      wr_ok        <= 1'b0;
    end else begin
      state       <= next;
      pid_valid_q <= 1'b0;

      // Packet start: EIDLE keeps the error visible until this point.
      if (idle_st && bus.d_edge) begin
        r_error_q    <= 1'b0;
        byte_count_q <= 7'd0;
      end

      // Registered on entry so r_error rises together with the ERR state.
      if (next == ERR) r_error_q <= 1'b1;

      if (state == PID_CHK && next == DATA_WAIT) begin
        pid_out_q   <= bus.rcv_data[3:0];
        pid_valid_q <= 1'b1;
      end

      if (state == DATA_WAIT && bus.byte_received)
        wr_ok <= !bus.fifo_full && (byte_count_q != MAX_CNT);

      // A refused write leaves byte_count at its value, so it saturates
      // at MAX_BYTES without any extra clamp.
      if (state == STORE && wr_ok) byte_count_q <= byte_count_q + 7'd1;

      // Bit position within the current byte, used for EOP alignment.
      if (bus.byte_received || (idle_st && next != state))
        bit_cnt <= 3'd0;
      else if (bus.shift_enable && timer_en)
        bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // ---------------- outputs ----------------
  assign bus.rcving        = !idle_st;
  assign bus.disable_timer = !timer_en;
  assign bus.w_enable      = (state == STORE) && wr_ok;
  assign bus.r_error       = r_error_q;
  assign bus.pid_out       = pid_out_q;
  assign bus.pid_valid     = pid_valid_q;
  assign bus.byte_count    = byte_count_q;

endmodule
